vco_nco: RTL and testbench
==========================

# vco_nco

Synchronous numerically controlled oscillator that turns the loop filter's frequency word `f` (Hz) into the square-wave `vco` consumed by the phase-frequency detector. It replaces delay-based VCO modelling with a clock-exact phase accumulator, so the PLL loop closes in synthesizable logic. A frequency request is converted to a tuning word by a sequential divider. The new word is applied only at a phase wrap, so `vco` never glitches or produces a runt period.

## Interface
- `CLK_HZ`, default 100_000_000: frequency of `clk` in Hz.
- `F_MIN`, default 20_000: lower clamp on the requested frequency, in Hz.
- `F_MAX`, default 80_000: upper clamp in Hz; must be ≤ `CLK_HZ/2`.
- `F_INIT`, default 40_000: frequency in force after reset, in Hz.
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `enable`, input, 1: run the oscillator (driven from `nrst && swiptAlive` of the loop).
- `f`, input, 32: requested frequency in Hz, unsigned.
- `f_load`, input, 1: single-cycle strobe; captures `f`.
- `vco`, output, 1: oscillator output, equal to `acc[31]`.
- `vco_rise`, output, 1: one-cycle pulse in the cycle `acc` wraps.
- `tw`, output, 32: tuning word currently in force.
- `busy`, output, 1: a conversion is in progress or a word is pending.
- `clamped`, output, 1: the last captured `f` was outside [`F_MIN`, `F_MAX`].

## Operation
- Phase accumulator: `acc` is 32 bits. Each enabled cycle, `acc <= acc + tw` mod 2^32. A wrap is a carry out of the addition; `vco_rise` equals that carry, registered with `acc`.
- Tuning word: `tw = floor(fc * 2^32 / CLK_HZ)`, where `fc = min(max(f, F_MIN), F_MAX)`.
- Reset value `TW_INIT` is the same formula applied to `F_INIT`, evaluated at elaboration.
- Divider: restoring long division of the 64-bit dividend `{fc, 32'b0}` by `CLK_HZ`.
  - Exactly 64 iterations, one per cycle.
  - Remainder is 33 bits wide; the quotient keeps its low 32 bits.
- FSM states:
  - `IDLE`: on `f_load`, clamp `f` into `fc`, set `clamped`, and go to `DIV`.
  - `DIV`: run 64 iterations, then write the quotient to `tw_pend` and go to `WAIT_WRAP`.
  - `WAIT_WRAP`: when enabled, copy `tw_pend` to `tw` in the first wrap cycle and go to `IDLE`. When `enable` = 0, copy immediately and go to `IDLE`.
- `f_load` while the FSM is not in `IDLE`:
  - `f` is stored in a one-deep request register; the latest value wins and earlier ones are dropped.
  - The stored request starts a new `DIV` on the cycle after the FSM returns to `IDLE`.
- `enable` = 0:
  - `acc` is forced to 0, so `vco` = 0 and `vco_rise` = 0.
  - Conversions still run.
  - When `enable` rises, `acc` starts from 0, so the first `vco` rising edge comes after `ceil(2^31/tw)` cycles.
- `rst` clears everything in the same cycle and takes priority over all other inputs. After reset:
  - `acc` = 0, `vco` = 0, `vco_rise` = 0, `tw` = `TW_INIT`.
  - `busy` = 0, `clamped` = 0, FSM in `IDLE`, pending request cleared.
  - A conversion in progress is discarded.

## Timing
- `f_load` sampled in cycle n: `DIV` occupies cycles n+1 to n+64, and `tw_pend` is valid in cycle n+65.
- The new `tw` takes effect on the cycle after the first wrap at or after n+65. The addition in the wrap cycle itself still uses the old `tw`.
- `busy` is high from n+1 through the cycle `tw` is updated. If a stored request exists, `busy` stays high without a gap.
- `clamped` updates in cycle n+1 and holds until the next capture.
- `vco` period is `floor(2^32/tw)` or that value +1 cycles. The long-run mean is exactly `2^32/tw`.
- Duty cycle is 50% ± 1 cycle.

## Test plan
- Reset, enable=1, no load (CLK_HZ=100e6) -> `tw` = 1717986. Measure 100 `vco_rise` intervals: each is 2500 or 2501 cycles, and the mean is 2500.00 ± 0.01.
- `f_load` with f=50000 mid-period -> `busy` rises at n+1. `tw` becomes 2147483 only on the cycle after the first wrap at or after n+65. No `vco` period is shorter than 2000 cycles, and later intervals are 2000 or 2001 cycles.
- Clamp: f=10 -> `tw` = 858993, `clamped` = 1. Then f=200000 -> `tw` = 3435973, `clamped` = 1. Then f=60000 -> `clamped` = 0.
- Back-to-back: `f_load` with f=30000, then f=70000 and f=45000 while busy -> only 30000 (tw=1288490) and then 45000 (tw=1932735) are applied; 70000 is never applied. `busy` stays high continuously.
- enable=0 with a load of f=60000 -> `vco` and `acc` stay 0, and `tw` = 2576980 at n+65. Then enable=1 -> first `vco_rise` occurs 1666 or 1667 cycles later.
- `rst` asserted in the middle of `DIV` -> next cycle `tw` = 1717986, `busy` = 0, `acc` = 0. No stale word is ever applied.

Source files
------------

// File: rtl/vco_nco.sv
// vco_nco: phase-accumulator NCO; a 64-step restoring divider turns the requested Hz into a tuning word,
// which is swapped in only on a phase wrap so vco never produces a runt period.
module vco_nco #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned F_MIN  = 20_000,
  parameter int unsigned F_MAX  = 80_000,
  parameter int unsigned F_INIT = 40_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] f,
  input  logic        f_load,
  output logic        vco,
  output logic        vco_rise,
  output logic [31:0] tw,
  output logic        busy,
  output logic        clamped
);
  localparam logic [31:0] TW_INIT = 32'({32'(F_INIT), 32'd0} / 64'(CLK_HZ));
  localparam logic [32:0] DIVISOR = 33'(CLK_HZ);
  typedef enum logic [1:0] {IDLE, DIV, WAIT_WRAP} state_t;
  state_t state, state_nx;
  logic [31:0] acc, tw_pend, req_f, src_f, fc, rem, rem_nx, quo, quo_nx;
  logic [63:0] dvd;
  logic [32:0] sum, rem_sh;
  logic [5:0] cnt;
  logic req_v, start, wrap, ge, last;
  assign sum = {1'b0, acc} + {1'b0, tw};
  assign wrap = enable & sum[32];
  assign vco = acc[31];
  assign busy = (state != IDLE) | req_v;
  assign start = (state == IDLE) & (f_load | req_v);
  assign src_f = f_load ? f : req_f;
  assign fc = src_f < F_MIN ? F_MIN : src_f > F_MAX ? F_MAX : src_f;
  // one restoring-division step per cycle, dividend bits shifted in MSB first
  assign rem_sh = {rem, dvd[63]};
  assign ge = rem_sh >= DIVISOR;
  assign rem_nx = ge ? 32'(rem_sh - DIVISOR) : rem_sh[31:0];
  assign quo_nx = {quo[30:0], ge};
  assign last = cnt == 6'd63;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? DIV : IDLE;
      DIV:       state_nx = last ? (enable ? WAIT_WRAP : IDLE) : DIV;
      WAIT_WRAP: state_nx = (wrap | ~enable) ? IDLE : WAIT_WRAP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      vco_rise <= 1'b0;
      tw <= TW_INIT;
      tw_pend <= TW_INIT;
      req_v <= 1'b0;
      req_f <= '0;
      clamped <= 1'b0;
      dvd <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else begin
      acc <= enable ? sum[31:0] : '0;
      vco_rise <= wrap;
      if (f_load && state != IDLE) begin
        req_v <= 1'b1;
        req_f <= f;
      end else if (start) req_v <= 1'b0;
      if (start) begin
        dvd <= {fc, 32'd0};
        rem <= '0;
        quo <= '0;
        cnt <= '0;
        clamped <= (src_f < F_MIN) | (src_f > F_MAX);
      end else if (state == DIV) begin
        dvd <= dvd << 1;
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 6'd1;
      end
      if (state == DIV && last) tw_pend <= quo_nx;
      // with the oscillator stopped there is no wrap to wait for, so the word lands at once
      if (state == DIV && last && !enable) tw <= quo_nx;
      else if (state == WAIT_WRAP && (wrap || !enable)) tw <= tw_pend;
    end
  end
endmodule

// File: tb/tb_vco_nco.sv
// tb_vco_nco: randomized bench; wrap cycles are predicted as ceil((2^32 - phase)/tw) from the last wrap,
// tuning words as floor(clamp(f) * 2^32 / CLK_HZ).
module tb_vco_nco;
  localparam longint unsigned CLK = 100_000_000;
  localparam longint unsigned FMIN = 20_000;
  localparam longint unsigned FMAX = 80_000;
  localparam longint unsigned FINIT = 40_000;
  localparam longint unsigned P32 = 64'h1_0000_0000;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, f_load = 1'b0;
  logic [31:0] f = '0;
  logic [31:0] tw;
  logic vco, vco_rise, busy, clamped;
  int checks = 0, errors = 0;
  longint unsigned cyc = 0, rises = 0;
  longint unsigned m_l, m_a, m_tw, m_rises;

  vco_nco dut (.clk(clk), .rst(rst), .enable(enable), .f(f), .f_load(f_load), .vco(vco),
               .vco_rise(vco_rise), .tw(tw), .busy(busy), .clamped(clamped));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vco_rise) rises <= rises + 1;
  end

  function automatic longint unsigned tw_of(input longint unsigned fr);
    longint unsigned fc;
    fc = fr < FMIN ? FMIN : fr > FMAX ? FMAX : fr;
    return (fc << 32) / CLK;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input longint unsigned t);
    while (cyc < t) step();
  endtask

  // next wrap: cycle m_l is where phase m_a is visible; the wrap pulse shows once the phase passes 2^32
  task automatic model_adv();
    longint unsigned d;
    d = (P32 - m_a + m_tw - 1) / m_tw;
    m_l += d;
    m_a = m_a + d * m_tw - P32;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    f_load = 1'b0;
    repeat (3) step();
    checks++; if (tw !== 32'(tw_of(FINIT))) begin errors++; $display("FAIL reset_tw got %0d want %0d", tw, tw_of(FINIT)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL reset_clamped got %b want 0", clamped); end
    checks++; if (vco !== 1'b0 || vco_rise !== 1'b0) begin errors++; $display("FAIL reset_vco got %b/%b want 0/0", vco, vco_rise); end
    checks++; if (dut.acc !== 32'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", dut.acc); end
    rst = 1'b0;
    m_l = cyc;
    m_a = 0;
    m_tw = tw_of(FINIT);
    m_rises = rises;
  endtask

  task automatic test_free_run();
    for (int j = 0; j < 8; j++) begin
      model_adv();
      goto(m_l - 1);
      checks++; if (vco_rise !== 1'b0) begin errors++; $display("FAIL free_early cycle %0d got rise %b want 0", cyc, vco_rise); end
      step();
      checks++;
      if (vco_rise !== 1'b1 || rises != m_rises || tw !== 32'(m_tw)) begin
        errors++;
        $display("FAIL free_rise cycle %0d got rise %b count %0d tw %0d want 1 %0d %0d", cyc, vco_rise, rises, tw, m_rises, m_tw);
      end
      m_rises++;
    end
  endtask

  task automatic test_retune();
    longint unsigned n, tw1;
    bit done;
    repeat ($urandom_range(100, 1500)) step();
    f = 32'd50000;
    f_load = 1'b1;
    n = cyc;
    step();
    f_load = 1'b0;
    checks++; if (busy !== 1'b1 || clamped !== 1'b0) begin errors++; $display("FAIL retune_busy got %b/%b want 1/0", busy, clamped); end
    tw1 = tw_of(50000);
    done = 1'b0;
    while (!done) begin
      model_adv();
      goto(m_l - 1);
      checks++;
      if (tw !== 32'(m_tw) || busy !== 1'b1 || vco_rise !== 1'b0) begin
        errors++;
        $display("FAIL retune_pre cycle %0d got tw %0d busy %b rise %b want %0d 1 0", cyc, tw, busy, vco_rise, m_tw);
      end
      step();
      done = (m_l - 1) >= (n + 65);
      if (done) m_tw = tw1;
      checks++;
      if (vco_rise !== 1'b1 || rises != m_rises || tw !== 32'(m_tw) || busy !== !done) begin
        errors++;
        $display("FAIL retune_wrap cycle %0d got rise %b count %0d tw %0d busy %b want 1 %0d %0d %b", cyc, vco_rise, rises, tw, busy, m_rises, m_tw, !done);
      end
      m_rises++;
    end
    for (int j = 0; j < 3; j++) begin
      model_adv();
      goto(m_l - 1);
      step();
      checks++;
      if (vco_rise !== 1'b1 || rises != m_rises || tw !== 32'(m_tw)) begin
        errors++;
        $display("FAIL retune_after cycle %0d got rise %b count %0d tw %0d want 1 %0d %0d", cyc, vco_rise, rises, tw, m_rises, m_tw);
      end
      m_rises++;
    end
  endtask

  task automatic test_clamp();
    longint unsigned fv [8];
    longint unsigned n, prev;
    logic want_c;
    fv[0] = 10;
    fv[1] = 200000;
    fv[2] = 60000;
    for (int k = 3; k < 8; k++) fv[k] = longint'($urandom_range(0, 120000));
    enable = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      prev = m_tw;
      f = 32'(fv[k]);
      f_load = 1'b1;
      n = cyc;
      step();
      f_load = 1'b0;
      want_c = (fv[k] < FMIN) || (fv[k] > FMAX);
      checks++; if (busy !== 1'b1 || clamped !== want_c) begin errors++; $display("FAIL clamp_flag f=%0d got busy %b clamped %b want 1 %b", fv[k], busy, clamped, want_c); end
      goto(n + 64);
      checks++; if (busy !== 1'b1 || tw !== 32'(prev)) begin errors++; $display("FAIL clamp_hold f=%0d got busy %b tw %0d want 1 %0d", fv[k], busy, tw, prev); end
      step();
      m_tw = tw_of(fv[k]);
      checks++;
      if (busy !== 1'b0 || tw !== 32'(m_tw) || vco !== 1'b0 || dut.acc !== 32'd0) begin
        errors++;
        $display("FAIL clamp_tw f=%0d got tw %0d busy %b vco %b acc %0d want %0d 0 0 0", fv[k], tw, busy, vco, dut.acc, m_tw);
      end
    end
  endtask

  task automatic test_enable();
    longint unsigned n;
    bit bad;
    enable = 1'b0;
    f = 32'd60000;
    f_load = 1'b1;
    n = cyc;
    step();
    f_load = 1'b0;
    bad = 1'b0;
    while (cyc < n + 65) begin
      if (vco !== 1'b0 || vco_rise !== 1'b0 || dut.acc !== 32'd0) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL en_off_acc got nonzero phase want 0"); end
    m_tw = tw_of(60000);
    checks++; if (tw !== 32'(m_tw) || busy !== 1'b0 || vco !== 1'b0) begin errors++; $display("FAIL en_off_tw got tw %0d busy %b vco %b want %0d 0 0", tw, busy, vco, m_tw); end
    repeat ($urandom_range(1, 20)) step();
    enable = 1'b1;
    m_l = cyc;
    m_a = 0;
    m_rises = rises;
    model_adv();
    goto(m_l - 1);
    checks++; if (vco_rise !== 1'b0 || rises != m_rises) begin errors++; $display("FAIL en_early got rise %b count %0d want 0 %0d", vco_rise, rises, m_rises); end
    step();
    checks++; if (vco_rise !== 1'b1) begin errors++; $display("FAIL en_first_rise cycle %0d got %b want 1", cyc, vco_rise); end
    m_rises++;
  endtask

  task automatic test_back_to_back();
    longint unsigned thr, nxt;
    int stage;
    bit bad;
    repeat ($urandom_range(50, 500)) step();
    f = 32'd30000;
    f_load = 1'b1;
    thr = cyc + 65;
    step();
    f_load = 1'b0;
    repeat ($urandom_range(5, 30)) step();
    f = 32'd70000;
    f_load = 1'b1;
    step();
    f_load = 1'b0;
    repeat ($urandom_range(5, 20)) step();
    f = 32'd45000;
    f_load = 1'b1;
    step();
    f_load = 1'b0;
    nxt = tw_of(30000);
    stage = 0;
    bad = 1'b0;
    while (stage < 2) begin
      model_adv();
      while (cyc + 1 < m_l) begin
        step();
        if (busy !== 1'b1 || tw !== 32'(m_tw) || vco_rise !== 1'b0) bad = 1'b1;
      end
      step();
      if (m_l - 1 >= thr) begin
        m_tw = nxt;
        stage++;
        thr = m_l + 65;
        nxt = tw_of(45000);
      end
      checks++;
      if (vco_rise !== 1'b1 || rises != m_rises || tw !== 32'(m_tw) || busy !== (stage < 2)) begin
        errors++;
        $display("FAIL b2b_wrap cycle %0d got rise %b count %0d tw %0d busy %b want 1 %0d %0d %b", cyc, vco_rise, rises, tw, busy, m_rises, m_tw, stage < 2);
      end
      m_rises++;
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_between got busy gap or unexpected tw/rise want steady busy"); end
  endtask

  task automatic test_reset_mid_div();
    bit bad;
    f = 32'($urandom_range(0, 200000));
    f_load = 1'b1;
    step();
    f_load = 1'b0;
    repeat ($urandom_range(5, 55)) step();
    rst = 1'b1;
    step();
    checks++; if (tw !== 32'(tw_of(FINIT)) || busy !== 1'b0) begin errors++; $display("FAIL rst_div_tw got tw %0d busy %b want %0d 0", tw, busy, tw_of(FINIT)); end
    checks++; if (dut.acc !== 32'd0 || vco_rise !== 1'b0 || clamped !== 1'b0) begin errors++; $display("FAIL rst_div_acc got acc %0d rise %b clamped %b want 0 0 0", dut.acc, vco_rise, clamped); end
    rst = 1'b0;
    m_l = cyc;
    m_a = 0;
    m_tw = tw_of(FINIT);
    m_rises = rises;
    bad = 1'b0;
    for (int j = 0; j < 2; j++) begin
      model_adv();
      while (cyc + 1 < m_l) begin
        step();
        if (busy !== 1'b0 || tw !== 32'(m_tw) || vco_rise !== 1'b0) bad = 1'b1;
      end
      step();
      checks++;
      if (vco_rise !== 1'b1 || rises != m_rises || tw !== 32'(m_tw)) begin
        errors++;
        $display("FAIL rst_div_rise cycle %0d got rise %b count %0d tw %0d want 1 %0d %0d", cyc, vco_rise, rises, tw, m_rises, m_tw);
      end
      m_rises++;
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_div_stale got busy or tw change after reset want none"); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_retune();
    test_clamp();
    test_enable();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
